// File: rtl/bitlogic_sched_pkg.sv
// Shared types and constants for the bitlogic_sched block: opcodes, FSM states, widths.
package bitlogic_sched_pkg;

  localparam int DEF_SLICE_W = 32;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_OP_W    = 2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/bitlogic_sched_logic32b.sv
// Purely combinational slice-wide bitwise unit (AND/OR/XOR/pass A) shared by both requesters.
module logic32b
  import bitlogic_sched_pkg::*;
#(
  parameter int W    = DEF_SLICE_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  input  logic [OP_W-1:0] op,
  output logic [W-1:0]    Y
);

  always_comb begin
    Y = A;
    case (op)
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/bitlogic_sched.sv
// Round-robin scheduler sharing one 32-bit logic unit between two requesters; 64-bit ops take two passes.
// Optional stall counters perf_stall0/perf_stall1 are built when BITLOGIC_SCHED_PERF_EN is defined.
module bitlogic_sched
  import bitlogic_sched_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_wide,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_wide,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data
`ifdef BITLOGIC_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_stall0,
  output logic [15:0]       perf_stall1
`endif
);

  state_t              state;
  logic                last_grant;
  logic [OP_W-1:0]     cur_op;
  logic                cur_wide;
  logic [DATA_W-1:0]   cur_a;
  logic [DATA_W-1:0]   cur_b;
  logic                grant0;
  logic                grant1;
  logic [SLICE_W-1:0]  unit_a;
  logic [SLICE_W-1:0]  unit_b;
  logic [SLICE_W-1:0]  unit_y;

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == ST_IDLE) && !reset && grant0;
    req1_ready = (state == ST_IDLE) && !reset && grant1;
  end

  always_comb begin
    unit_a = cur_a[SLICE_W-1:0];
    unit_b = cur_b[SLICE_W-1:0];
    if (state == ST_HI) begin
      unit_a = cur_a[DATA_W-1:SLICE_W];
      unit_b = cur_b[DATA_W-1:SLICE_W];
    end
  end

  logic32b #(.W(SLICE_W), .OP_W(OP_W)) u_unit (
    .A  (unit_a),
    .B  (unit_b),
    .op (cur_op),
    .Y  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cur_op     <= '0;
      cur_wide   <= 1'b0;
      cur_a      <= '0;
      cur_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            cur_op     <= grant1 ? req1_op   : req0_op;
            cur_wide   <= grant1 ? req1_wide : req0_wide;
            cur_a      <= grant1 ? req1_a    : req0_a;
            cur_b      <= grant1 ? req1_b    : req0_b;
            resp_id    <= grant1;
            last_grant <= grant1;
            state      <= ST_LO;
          end
        end
        ST_LO: begin
          resp_data[SLICE_W-1:0] <= unit_y;
          if (cur_wide) begin
            state <= ST_HI;
          end else begin
            // Narrow ops sign-extend like RV64 W-form results.
            resp_data[DATA_W-1:SLICE_W] <= {SLICE_W{unit_y[SLICE_W-1]}};
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_HI: begin
          resp_data[DATA_W-1:SLICE_W] <= unit_y;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BITLOGIC_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else begin
      if (req0_valid && !req0_ready && (perf_stall0 != 16'hFFFF))
        perf_stall0 <= perf_stall0 + 16'd1;
      if (req1_valid && !req1_ready && (perf_stall1 != 16'hFFFF))
        perf_stall1 <= perf_stall1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bitlogic_sched.sv
// Directed self-checking bench for bitlogic_sched; perf counter checks compile in with BITLOGIC_SCHED_PERF_EN.
module tb_bitlogic_sched;
  import bitlogic_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic        req0_wide = 1'b0, req1_wide = 1'b0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_id;
  logic [63:0] resp_data;
`ifdef BITLOGIC_SCHED_PERF_EN
  logic [15:0] perf_stall0, perf_stall1;
  logic [15:0] stall_snap;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  bitlogic_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_wide  (req0_wide),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_wide  (req1_wide),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef BITLOGIC_SCHED_PERF_EN
    ,
    .perf_stall0 (perf_stall0),
    .perf_stall1 (perf_stall1)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its grant, then count cycles from the handshake until resp_valid.
  task automatic applyStimulus(input int port, input logic [1:0] op, input logic wide,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic scramble, output int latency);
    logic got;
    @(negedge clk);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_wide = wide; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_wide = wide; req1_a = a; req1_b = b;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    checkOutput("grant", {63'd0, got}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (scramble) begin
      req0_a = ~req0_a; req0_b = ~req0_b; req0_op = req0_op ^ 2'b01; req0_wide = ~req0_wide;
      req1_a = ~req1_a; req1_b = ~req1_b; req1_op = req1_op ^ 2'b01; req1_wide = ~req1_wide;
    end
    latency = 1;
    while (!resp_valid && latency < 20) begin
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic takeResponse();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_drop", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int last_cyc;
    logic seen;

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("rst_data", resp_data, 64'd0);
    checkOutput("rst_id", {63'd0, resp_id}, 64'd0);
    checkOutput("rst_rdy0", {63'd0, req0_ready}, 64'd0);
    checkOutput("rst_rdy1", {63'd0, req1_ready}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle_rdy0", {63'd0, req0_ready}, 64'd0);

    // Wide XOR from requester 0
    applyStimulus(0, OP_XOR, 1'b1, 64'hFFFF0000_12345678, 64'h0F0F0F0F_FFFF0000, 1'b0, lat);
    checkOutput("wide_lat", lat, 3);
    checkOutput("wide_data", resp_data, 64'hF0F00F0F_EDCB5678);
    checkOutput("wide_id", {63'd0, resp_id}, 64'd0);
    takeResponse();

    // Narrow OR from requester 1, negative result sign-extends
    applyStimulus(1, OP_OR, 1'b0, 64'h0, 64'h00000000_80000001, 1'b0, lat);
    checkOutput("narrow_lat", lat, 2);
    checkOutput("narrow_or", resp_data, 64'hFFFFFFFF_80000001);
    checkOutput("narrow_id", {63'd0, resp_id}, 64'd1);
    takeResponse();

    // Narrow AND with positive result: upper half zero despite nonzero upper operands
    applyStimulus(0, OP_AND, 1'b0, 64'hAAAAAAAA_7FFFFFFF, 64'h55555555_F0F0F0F0, 1'b0, lat);
    checkOutput("and_lat", lat, 2);
    checkOutput("narrow_and", resp_data, 64'h00000000_70F0F0F0);
    takeResponse();

    // Operands changed right after handshake must not affect the result
    applyStimulus(0, OP_AND, 1'b1, 64'h12345678_9ABCDEF0, 64'hFF00FF00_0F0F0F0F, 1'b1, lat);
    checkOutput("cap_lat", lat, 3);
    checkOutput("cap_data", resp_data, 64'h12005600_0A0C0E00);
    takeResponse();

    // Fresh reset so the first tie goes to requester 0, then both requesters stay valid
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req0_valid = 1'b1; req0_op = OP_AND; req0_wide = 1'b0;
    req0_a = 64'h00000000_0F0F0F0F; req0_b = 64'hFFFFFFFF_FFFFFFFF;
    req1_valid = 1'b1; req1_op = OP_OR; req1_wide = 1'b0;
    req1_a = 64'h00000000_000000F0; req1_b = 64'h00000000_0000000F;
    resp_ready = 1'b1;
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        checkOutput("fair_id", {63'd0, resp_id}, {63'd0, n[0]});
        checkOutput("fair_data", resp_data, n[0] ? 64'h00000000_000000FF : 64'h00000000_0F0F0F0F);
        if (n > 0) checkOutput("fair_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        n++;
        if (n == 6) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
          break;
        end
      end
    end
    checkOutput("fair_count", n, 6);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("fair_idle", {63'd0, resp_valid}, 64'd0);

    // Back-pressure: response held while requester 1 waits
    applyStimulus(0, OP_XOR, 1'b0, 64'h00000000_00001234, 64'h00000000_000000FF, 1'b0, lat);
    checkOutput("stall_lat", lat, 2);
    req1_valid = 1'b1; req1_op = OP_OR; req1_wide = 1'b0;
`ifdef BITLOGIC_SCHED_PERF_EN
    stall_snap = perf_stall1;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("stall_data", resp_data, 64'h00000000_000012CB);
      checkOutput("stall_id", {63'd0, resp_id}, 64'd0);
      checkOutput("stall_rdy1", {63'd0, req1_ready}, 64'd0);
    end
`ifdef BITLOGIC_SCHED_PERF_EN
    checkOutput("perf_stall1", {48'd0, perf_stall1 - stall_snap}, 64'd5);
`endif
    req1_valid = 1'b0;
    takeResponse();

    // Reset during the high pass of a wide op aborts it
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_XOR; req0_wide = 1'b1;
    req0_a = 64'h11111111_22222222; req0_b = 64'h0;
    #1;
    checkOutput("abort_grant", {63'd0, req0_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("abort_data", resp_data, 64'd0);
    checkOutput("abort_id", {63'd0, resp_id}, 64'd0);
    checkOutput("abort_rdy0", {63'd0, req0_ready}, 64'd0);
    checkOutput("abort_rdy1", {63'd0, req1_ready}, 64'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    checkOutput("abort_no_resp", {63'd0, seen}, 64'd0);

    applyStimulus(0, OP_PASS, 1'b1, 64'hDEADBEEF_CAFEF00D, 64'h00000000_00000123, 1'b0, lat);
    checkOutput("pass_lat", lat, 3);
    checkOutput("pass_data", resp_data, 64'hDEADBEEF_CAFEF00D);
    takeResponse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
